// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, FSM state encoding and fetch-buffer entry type for the IF stage.
// Optional trace output in instr_fetch_unit is enabled by defining IF_TRACE_EN.
package instr_fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] CPU_RST_ADDR = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buf.sv
// Synchronous FIFO of {pc, instr} fetch results; flush empties it in one edge.
// Same-edge push and pop are legal at any occupancy, including full.
module instr_fetch_unit_fetch_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over imem req/ack, buffers words and feeds IF/ID.
// Define IF_TRACE_EN to $display every pop and every redirect target.
//
// state   | meaning
// IF_IDLE | buffer full, no request outstanding
// IF_REQ  | request to addr_q outstanding (req_q=0 only in the cycle after reset)
// IF_DROP | request outstanding for a stale address; its ack'd word is discarded
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RST_ADDR  = CPU_RST_ADDR,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i_IF,
  input  logic        rst_i_IF,
  input  logic        stall_i_IF,
  input  logic        redirect_i_IF,
  input  logic [31:0] redirect_pc_i_IF,
  output logic        imem_req_o_IF,
  output logic [31:0] imem_addr_o_IF,
  input  logic        imem_ack_i_IF,
  input  logic [31:0] imem_rdata_i_IF,
  output logic [31:0] instr_o_IF,
  output logic [31:0] pc_addr_o_IF,
  output logic        valid_o_IF
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  if_state_e     state_q;
  logic          req_q;
  logic [31:0]   pc_q, addr_q;
  logic [31:0]   instr_q, pc_addr_q;
  logic          valid_q;

  logic [31:0]   redirect_pc;
  logic          buf_push, buf_pop, buf_full, buf_empty, room_after_push;
  logic [CW-1:0] buf_count, occ_after;
  fetch_entry_t  buf_head;

  assign redirect_pc = word_align(redirect_pc_i_IF);
  assign buf_pop     = !redirect_i_IF && !stall_i_IF && !buf_empty;
  assign buf_push    = (state_q == IF_REQ) && req_q && imem_ack_i_IF && !redirect_i_IF;
  assign occ_after   = buf_count + CW'(buf_push) - CW'(buf_pop);
  assign room_after_push = (occ_after < CW'(BUF_DEPTH));

  instr_fetch_unit_fetch_buf #(.DEPTH(BUF_DEPTH)) u_fetch_buf (
    .clk_i   (clk_i_IF),
    .rst_i   (rst_i_IF),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (redirect_i_IF),
    .wdata_i ('{pc: pc_q, instr: imem_rdata_i_IF}),
    .rdata_o (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // addr_q is held through DROP so the address stays stable while the stale request completes
  always_ff @(posedge clk_i_IF) begin
    if (rst_i_IF) begin
      state_q <= IF_REQ;
      req_q   <= 1'b0;
      pc_q    <= RST_ADDR;
      addr_q  <= RST_ADDR;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (redirect_i_IF) begin
            pc_q    <= redirect_pc;
            addr_q  <= redirect_pc;
            state_q <= IF_REQ;
            req_q   <= 1'b1;
          end else if (!buf_full || buf_pop) begin
            state_q <= IF_REQ;
            req_q   <= 1'b1;
          end
        end
        IF_REQ: begin
          if (!req_q) begin
            req_q <= 1'b1;
            if (redirect_i_IF) begin
              pc_q   <= redirect_pc;
              addr_q <= redirect_pc;
            end
          end else if (redirect_i_IF) begin
            pc_q <= redirect_pc;
            if (imem_ack_i_IF) addr_q <= redirect_pc;
            else               state_q <= IF_DROP;
          end else if (imem_ack_i_IF) begin
            pc_q   <= pc_q + 32'd4;
            addr_q <= pc_q + 32'd4;
            if (!room_after_push) begin
              state_q <= IF_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        IF_DROP: begin
          if (redirect_i_IF) pc_q <= redirect_pc;
          if (imem_ack_i_IF) begin
            state_q <= IF_REQ;
            addr_q  <= redirect_i_IF ? redirect_pc : pc_q;
          end
        end
        default: begin
          state_q <= IF_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i_IF) begin
    if (rst_i_IF) begin
      instr_q   <= INSTR_NOP;
      pc_addr_q <= RST_ADDR;
      valid_q   <= 1'b0;
    end else if (redirect_i_IF) begin
      instr_q <= INSTR_NOP;
      valid_q <= 1'b0;
    end else if (!stall_i_IF) begin
      if (!buf_empty) begin
        instr_q   <= buf_head.instr;
        pc_addr_q <= buf_head.pc;
        valid_q   <= 1'b1;
      end else begin
        instr_q <= INSTR_NOP;
        valid_q <= 1'b0;
      end
    end
  end

`ifdef IF_TRACE_EN
  always_ff @(posedge clk_i_IF) begin
    if (!rst_i_IF) begin
      if (buf_pop)       $display("IF pop pc=%h instr=%h", buf_head.pc, buf_head.instr);
      if (redirect_i_IF) $display("IF redirect target=%h", redirect_pc);
    end
  end
`else
  // trace disabled: no extra logic
`endif

  assign imem_req_o_IF  = req_q;
  assign imem_addr_o_IF = addr_q;
  assign instr_o_IF     = instr_q;
  assign pc_addr_o_IF   = pc_addr_q;
  assign valid_o_IF     = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a streaming sequence.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redir, ack;
  logic [31:0] rpc, rdata;
  logic        req_o, valid_o;
  logic [31:0] addr_o, instr_o, pc_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RST_ADDR(32'h0), .BUF_DEPTH(2)) dut (
    .clk_i_IF         (clk),
    .rst_i_IF         (rst),
    .stall_i_IF       (stall),
    .redirect_i_IF    (redir),
    .redirect_pc_i_IF (rpc),
    .imem_req_o_IF    (req_o),
    .imem_addr_o_IF   (addr_o),
    .imem_ack_i_IF    (ack),
    .imem_rdata_i_IF  (rdata),
    .instr_o_IF       (instr_o),
    .pc_addr_o_IF     (pc_o),
    .valid_o_IF       (valid_o)
  );

  typedef struct {
    logic        rst, stall, redir, ack;
    logic [31:0] rpc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  task automatic add(input logic r, s, d, input logic [31:0] p, input logic a,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.rpc = p; v.ack = a;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    chk({tag, " req"},   {31'b0, req_o},   {31'b0, er});
    chk({tag, " addr"},  addr_o,           ea);
    chk({tag, " valid"}, {31'b0, valid_o}, {31'b0, ev});
    chk({tag, " pc"},    pc_o,             ep);
    chk({tag, " instr"}, instr_o,          ei);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; ack = 1'b0; rpc = '0; rdata = '0;

    //   rst stall redir rpc           ack | req addr          valid pc            instr
    // reset, then 1-cycle-latency fetch of 0,4,8,C
    add(1, 0, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h4,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h4,         1, 32'h0,         w(32'h0));
    add(0, 0, 0, 32'h0,         1,   1, 32'h8,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h8,         1, 32'h4,         w(32'h4));
    add(0, 0, 0, 32'h0,         1,   1, 32'hC,         0, 32'h4,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'hC,         1, 32'h8,         w(32'h8));
    // stall 6 cycles with ack held high: buffer fills, req drops, outputs frozen
    add(0, 1, 0, 32'h0,         1,   1, 32'h10,        1, 32'h8,         w(32'h8));
    add(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         w(32'h8));
    add(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         w(32'h8));
    add(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         w(32'h8));
    add(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         w(32'h8));
    add(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         w(32'h8));
    add(0, 0, 0, 32'h0,         1,   1, 32'h14,        1, 32'hC,         w(32'hC));
    add(0, 0, 0, 32'h0,         1,   1, 32'h18,        1, 32'h10,        w(32'h10));
    add(0, 0, 0, 32'h0,         0,   1, 32'h18,        1, 32'h14,        w(32'h14));
    // redirect to 0x100 while request to 0x18 is outstanding (3-cycle ack)
    add(0, 0, 0, 32'h0,         0,   1, 32'h18,        0, 32'h14,        NOP);
    add(0, 0, 1, 32'h100,       0,   1, 32'h18,        0, 32'h14,        NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h18,        0, 32'h14,        NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h14,        NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h100,       0, 32'h14,        NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h104,       0, 32'h14,        NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h104,       1, 32'h100,       w(32'h100));
    // redirect with ack in the same cycle: no DROP, next request is 0x100
    add(0, 0, 1, 32'h100,       1,   1, 32'h100,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h104,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h104,       1, 32'h100,       w(32'h100));
    // unaligned redirect target
    add(0, 0, 1, 32'h203,       1,   1, 32'h200,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h200,       0, 32'h100,       NOP);
    // fill under stall, then redirect with stall still high must flush
    add(0, 1, 0, 32'h0,         1,   1, 32'h204,       0, 32'h100,       NOP);
    add(0, 1, 0, 32'h0,         1,   0, 32'h208,       0, 32'h100,       NOP);
    add(0, 1, 1, 32'h300,       0,   1, 32'h300,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h300,       0, 32'h100,       NOP);
    // redirect into DROP, second redirect while in DROP only moves pc
    add(0, 0, 1, 32'h400,       0,   1, 32'h300,       0, 32'h100,       NOP);
    add(0, 0, 1, 32'h500,       0,   1, 32'h300,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h500,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h504,       0, 32'h100,       NOP);
    add(0, 1, 0, 32'h0,         1,   0, 32'h508,       0, 32'h100,       NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h508,       1, 32'h500,       w(32'h500));
    add(0, 1, 0, 32'h0,         0,   1, 32'h508,       1, 32'h500,       w(32'h500));
    // reset mid-request with buffered data; reset overrides all other inputs
    add(1, 1, 1, 32'h700,       1,   0, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h4,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h4,         1, 32'h0,         w(32'h0));
    // pc wraps from 0xFFFF_FFFC to 0
    add(0, 0, 1, 32'hFFFF_FFFC, 1,   1, 32'hFFFF_FFFC, 0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         NOP);
    add(0, 0, 0, 32'h0,         0,   1, 32'h0,         1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      stall = vecs[i].stall;
      redir = vecs[i].redir;
      rpc   = vecs[i].rpc;
      ack   = vecs[i].ack;
      rdata = w(addr_o);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
              vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
    end

    // zero-latency memory: ack whenever req is up, so pops should stream back-to-back
    rst = 1'b1; stall = 1'b0; redir = 1'b0; ack = 1'b0; rpc = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      ack   = req_o;
      rdata = w(addr_o);
      @(negedge clk);
      if (n < 3)
        chk_all($sformatf("s%0d", n), 1'b1, (n == 1) ? 32'h0 : 32'(4 * (n - 1)),
                1'b0, 32'h0, NOP);
      else
        chk_all($sformatf("s%0d", n), 1'b1, 32'(4 * (n - 1)),
                1'b1, 32'(4 * (n - 3)), w(32'(4 * (n - 3))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
